// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA defaults, blend-mode codes and {R,G,B} channel order.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COLOR_BITS_DEF = 3;
  localparam int MODE_OR = 0;
  localparam int MODE_PRIORITY = 1;
  // Channel index within a packed pixel; channel c sits at [c*COLOR_BITS +: COLOR_BITS].
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;
endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay: WIDTH-bit shift register of DEPTH stages with sync reset value.
module vga_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [DEPTH*WIDTH-1:0] r_sh;
  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge i_CLK)
        r_sh <= i_RST ? RST_VAL : i_d;
    end else begin : g_many
      always_ff @(posedge i_CLK)
        r_sh <= i_RST ? {DEPTH{RST_VAL}} : {r_sh[(DEPTH-1)*WIDTH-1:0], i_d};
    end
  endgenerate
  assign o_q = r_sh[DEPTH*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: two-stage N-layer pixel compositor (OR or priority blend) with
// frame-latched layer enables, background colour, blanking and aligned syncs.
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_BITS = COLOR_BITS_DEF,
  parameter int MODE = MODE_OR,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [3*COLOR_BITS-1:0] BG_COLOR = '0
) (
  input  logic                               i_CLK,
  input  logic                               i_RST,
  input  logic                               i_hSync,
  input  logic                               i_vSync,
  input  logic [9:0]                         i_display_x_pos,
  input  logic [9:0]                         i_display_y_pos,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] i_layer_rgb,
  input  logic [NUM_LAYERS-1:0]              i_layer_valid,
  input  logic [NUM_LAYERS-1:0]              i_layer_en,
  output logic [COLOR_BITS-1:0]              o_red,
  output logic [COLOR_BITS-1:0]              o_green,
  output logic [COLOR_BITS-1:0]              o_blue,
  output logic                               o_hSync,
  output logic                               o_vSync,
  output logic                               o_frame_start
);
  localparam int PW = 3*COLOR_BITS;
  logic                       w_origin;
  logic [NUM_LAYERS-1:0]      w_en;
  logic [NUM_LAYERS-1:0]      r_en;
  logic [NUM_LAYERS-1:0]      r_cov;
  logic [NUM_LAYERS*PW-1:0]   r_rgb;
  logic                       r_act;
  logic [PW-1:0]              w_mix;
  logic [PW-1:0]              r_pix;
  assign w_origin = (i_display_x_pos == '0) && (i_display_y_pos == '0);
  // The frame-start load is visible to pixel (0,0) itself, hence the bypass.
  assign w_en = w_origin ? i_layer_en : r_en;
  always_ff @(posedge i_CLK)
    if (i_RST) begin
      r_en  <= '1;
      r_cov <= '0;
      r_rgb <= '0;
      r_act <= 1'b0;
      r_pix <= '0;
    end else begin
      r_en  <= w_en;
      r_cov <= i_layer_valid & w_en;
      r_rgb <= i_layer_rgb;
      r_act <= (32'(i_display_x_pos) < H_ACTIVE) && (32'(i_display_y_pos) < V_ACTIVE);
      r_pix <= r_act ? w_mix : '0;
    end
  // Priority walks high to low so the lowest covering index is written last.
  always_comb begin
    w_mix = '0;
    for (int k = NUM_LAYERS-1; k >= 0; k--)
      if (r_cov[k])
        w_mix = (MODE == MODE_PRIORITY) ? r_rgb[k*PW +: PW] : (w_mix | r_rgb[k*PW +: PW]);
    if (r_cov == '0)
      w_mix = BG_COLOR;
  end
  assign o_red   = r_pix[CH_R*COLOR_BITS +: COLOR_BITS];
  assign o_green = r_pix[CH_G*COLOR_BITS +: COLOR_BITS];
  assign o_blue  = r_pix[CH_B*COLOR_BITS +: COLOR_BITS];
  vga_pipe_delay #(.WIDTH(2), .DEPTH(2), .RST_VAL(2'b11)) u_sync_dly (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_d   ({i_hSync, i_vSync}),
    .o_q   ({o_hSync, o_vSync})
  );
  vga_pipe_delay #(.WIDTH(1), .DEPTH(2), .RST_VAL(1'b0)) u_fs_dly (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_d   (w_origin),
    .o_q   (o_frame_start)
  );
endmodule
